// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain initiator: serializes bitstream words MSB-first onto ccff_head
// while repacking the bits leaving ccff_tail into left-aligned readback words.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done
);
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
    localparam int BW        = $clog2(CHAIN_LEN + 1);
    localparam int CW        = $clog2(WORD_W + 1);
    localparam int IW        = $clog2(NW + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d, asm_q, asm_d, rb_data_q, rb_data_d;
    logic [CW-1:0]     wcnt_q, wcnt_d, acnt_q, acnt_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic              pend_q, pend_d, rb_valid_q, rb_valid_d;

    logic              shift, accept, complete, can_xfer, last_bit;
    logic [WORD_W-1:0] asm_c;
    logic [CW-1:0]     acnt_c, shamt;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        wcnt_d     = wcnt_q;
        bcnt_d     = bcnt_q;
        widx_d     = widx_q;
        asm_d      = asm_q;
        acnt_d     = acnt_q;
        pend_d     = pend_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = rb_valid_q;
        in_ready   = 1'b0;
        shift      = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        last_bit   = 1'b0;
        asm_c      = asm_q;
        acnt_c     = acnt_q;
        shamt      = '0;
        can_xfer   = !rb_valid_q || rb_ready;

        if (rb_valid_q && rb_ready) rb_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    bcnt_d  = '0;
                    widx_d  = '0;
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    asm_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            S_LOAD: begin
                in_ready = (wcnt_q == '0) && (widx_q < IW'(NW));
                accept   = in_ready && in_valid;
                // A blocked readback word freezes the chain so no tail bit is lost.
                shift    = (wcnt_q != '0) && !pend_q;
                if (accept) begin
                    word_d = in_data;
                    wcnt_d = (widx_q == IW'(NW - 1)) ? CW'(LAST_BITS) : CW'(WORD_W);
                    widx_d = widx_q + IW'(1);
                end
                if (shift) begin
                    word_d   = {word_q[WORD_W-2:0], 1'b0};
                    wcnt_d   = wcnt_q - CW'(1);
                    bcnt_d   = bcnt_q + BW'(1);
                    asm_c    = {asm_q[WORD_W-2:0], ccff_tail};
                    acnt_c   = acnt_q + CW'(1);
                    last_bit = (bcnt_q == BW'(CHAIN_LEN - 1));
                    if (last_bit) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (!pend_q && can_xfer) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        complete = pend_q || (shift && ((acnt_c == CW'(WORD_W)) || last_bit));
        if (complete) begin
            if (can_xfer) begin
                // Left-align a short final word so its first captured bit lands at the MSB.
                shamt      = CW'(WORD_W) - acnt_c;
                rb_data_d  = asm_c << shamt;
                rb_valid_d = 1'b1;
                asm_d      = '0;
                acnt_d     = '0;
                pend_d     = 1'b0;
            end else begin
                asm_d  = asm_c;
                acnt_d = acnt_c;
                pend_d = 1'b1;
            end
        end else if (shift) begin
            asm_d  = asm_c;
            acnt_d = acnt_c;
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            wcnt_q     <= '0;
            bcnt_q     <= '0;
            widx_q     <= '0;
            asm_q      <= '0;
            acnt_q     <= '0;
            pend_q     <= 1'b0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            wcnt_q     <= wcnt_d;
            bcnt_q     <= bcnt_d;
            widx_q     <= widx_d;
            asm_q      <= asm_d;
            acnt_q     <= acnt_d;
            pend_q     <= pend_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign ccff_shift_en = shift;
    assign ccff_head     = (wcnt_q != '0) ? word_q[WORD_W-1] : 1'b0;
    assign rb_data       = rb_data_q;
    assign rb_valid      = rb_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 40-bit chain model plus a 1-bit chain on a
// second instance; expected chain/readback contents come from a bit-stream model.
module tb_ccff_bitstream_loader;
    localparam int CL = 40;
    localparam int WW = 16;
    localparam int NW = (CL + WW - 1) / WW;

    logic          prog_clk   = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start      = 1'b0;
    logic          in_valid   = 1'b0;
    logic          rb_ready   = 1'b0;
    logic [WW-1:0] in_data    = '0;
    logic          in_ready, rb_valid, ccff_head, ccff_shift_en, busy, done, ccff_tail;
    logic [WW-1:0] rb_data;

    logic       s_start = 1'b0, s_in_valid = 1'b0, s_rb_ready = 1'b0;
    logic [1:0] s_in_data = '0;
    logic       s_in_ready, s_rb_valid, s_head, s_shift_en, s_busy, s_done, s_tail;
    logic [1:0] s_rb_data;

    int checks   = 0;
    int failures = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
        .busy(busy), .done(done)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(1), .WORD_W(2)) u_small (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(s_start),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .rb_data(s_rb_data), .rb_valid(s_rb_valid), .rb_ready(s_rb_ready),
        .ccff_head(s_head), .ccff_tail(s_tail), .ccff_shift_en(s_shift_en),
        .busy(s_busy), .done(s_done)
    );

    // Fabric chain models: head enters at bit 0, tail leaves from the top bit.
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] preload_val = '0;
    logic          preload_req = 1'b0;
    logic          s_chain = 1'b0, s_pre_val = 1'b0, s_pre_req = 1'b0;
    assign ccff_tail = chain[CL-1];
    assign s_tail    = s_chain;
    always @(posedge prog_clk) begin
        if (preload_req) chain <= preload_val;
        else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
        if (s_pre_req) s_chain <= s_pre_val;
        else if (s_shift_en) s_chain <= s_head;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int            cyc = 0, shifts = 0, dones = 0, rb_n = 0, start_cyc = 0, done_cyc = 0;
    logic [WW-1:0] rb_log [256];
    logic          hold_q = 1'b0;
    logic [WW-1:0] hold_data = '0;
    always @(negedge prog_clk) begin
        cyc++;
        if (!prog_reset) begin
            if (hold_q) chk("rb_stable", 64'({rb_valid, rb_data}), 64'({1'b1, hold_data}));
            if (ccff_shift_en) shifts++;
            if (done) begin dones++; done_cyc = cyc; end
            if (start && !busy) start_cyc = cyc;
            if (rb_valid && rb_ready) begin rb_log[rb_n[7:0]] = rb_data; rb_n++; end
            hold_q    = rb_valid && !rb_ready;
            hold_data = rb_data;
        end else begin
            hold_q = 1'b0;
        end
    end

    logic [WW-1:0] words [NW];
    logic [CL-1:0] exp_chain;
    logic [WW-1:0] exp_rb [NW];
    bit            rb_rand = 0, spam = 0;
    int            last_r0 = 0;

    // New chain = first CL bits of the word stream; readback = old chain in tail order.
    task automatic model(input logic [CL-1:0] init);
        logic [WW-1:0] wd;
        exp_chain = '0;
        for (int i = 0; i < NW; i++) exp_rb[i] = '0;
        for (int i = 0; i < CL; i++) begin
            wd = words[i / WW];
            exp_chain = {exp_chain[CL-2:0], wd[WW-1 - i % WW]};
            exp_rb[i / WW][WW-1 - i % WW] = init[CL-1-i];
        end
    endtask

    task automatic step();
        @(posedge prog_clk); #1;
        if (rb_rand) rb_ready = 1'($urandom_range(0, 1));
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic settle();
        @(negedge prog_clk); #1;
    endtask

    // mode: 0 rb_ready held 1, 1 random rb_ready, 2 rb_ready 0 until a stall is seen
    task automatic run_load(input int gap, input bit preload, input logic [CL-1:0] init,
                            input int mode, input bit spam_en, input int abort_at);
        int s0, d0, r0, guard, w, gl, sc;
        bit acc, raise, released, rel_now;
        if (preload) begin
            @(posedge prog_clk); #1; preload_val = init; preload_req = 1'b1;
            @(posedge prog_clk); #1; preload_req = 1'b0;
        end
        model(chain);
        s0 = shifts; d0 = dones; r0 = rb_n; last_r0 = r0;
        w = 0; gl = 0; sc = 0; guard = 0; released = 0;
        rb_ready = (mode != 2); rb_rand = (mode == 1);
        in_data = words[0]; in_valid = 1'b1; start = 1'b1;
        step();
        spam = spam_en;
        while (guard < 3000) begin
            settle(); guard++;
            if (done) break;
            if (abort_at > 0 && shifts - s0 >= abort_at) begin
                prog_reset = 1'b1; #1;
                chk("reset_outputs_async",
                    64'({in_ready, rb_valid, rb_data, ccff_head, ccff_shift_en, busy, done}), 64'(0));
                chk("reset_at_shift", 64'(shifts - s0), 64'(abort_at));
                spam = 0; rb_rand = 0; in_valid = 1'b0; start = 1'b0; rb_ready = 1'b1;
                step(); step(); prog_reset = 1'b0;
                step(); settle();
                chk("reset_idle", 64'({busy, ccff_shift_en, in_ready}), 64'(0));
                return;
            end
            acc = in_valid && in_ready;
            raise = 0; rel_now = 0;
            if (w == NW) chk("extra_word_not_ready", 64'(in_ready), 64'(0));
            if (!in_valid && w < NW && in_ready) begin
                chk("gap_no_shift", 64'(ccff_shift_en), 64'(0));
                gl--;
                if (gl <= 0) raise = 1;
            end
            if (mode == 2 && !released && shifts - s0 >= 2 * WW) begin
                sc++;
                if (sc == 8) begin
                    chk("stall_shifts", 64'(shifts - s0), 64'(2 * WW));
                    chk("stall_shift_en", 64'(ccff_shift_en), 64'(0));
                    chk("stall_rb", 64'({rb_valid, rb_data}), 64'({1'b1, exp_rb[0]}));
                    rel_now = 1;
                end
            end
            step();
            if (rel_now) begin rb_ready = 1'b1; released = 1; end
            if (acc) begin
                w++;
                if (w < NW) begin
                    in_data = words[w];
                    if (gap == 0) in_valid = 1'b1;
                    else begin in_valid = 1'b0; gl = gap; end
                end else begin
                    in_data = WW'($urandom); in_valid = 1'b1;
                end
            end else if (raise) begin
                in_valid = 1'b1;
            end
        end
        chk("done_seen", 64'(done), 64'(1));
        spam = 0; rb_rand = 0; start = 1'b0; in_valid = 1'b0; rb_ready = 1'b1;
        step(); settle();
        chk("idle_after_done", 64'({busy, done}), 64'(0));
        chk("shift_count", 64'(shifts - s0), 64'(CL));
        chk("done_count", 64'(dones - d0), 64'(1));
        chk("rb_count", 64'(rb_n - r0), 64'(NW));
        for (int i = 0; i < NW; i++) chk("rb_word", 64'(rb_log[(r0 + i) % 256]), 64'(exp_rb[i]));
        chk("chain_content", 64'(chain), 64'(exp_chain));
    endtask

    initial begin
        int ns, nrb, dat;
        repeat (3) @(posedge prog_clk);
        #1;
        settle();
        chk("reset_outputs",
            64'({in_ready, rb_valid, rb_data, ccff_head, ccff_shift_en, busy, done}), 64'(0));
        chk("reset_outputs_small",
            64'({s_in_ready, s_rb_valid, s_rb_data, s_head, s_shift_en, s_busy, s_done}), 64'(0));
        prog_reset = 1'b0;
        step();

        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9A00;
        run_load(0, 1, 40'hA5A5_A5A5_A5, 0, 0, 0);
        chk("s1_chain", 64'(chain), 64'(40'h12_3456_789A));
        chk("s1_rb0", 64'(rb_log[last_r0 % 256]), 64'(16'hA5A5));
        chk("s1_rb1", 64'(rb_log[(last_r0 + 1) % 256]), 64'(16'hA5A5));
        chk("s1_rb2", 64'(rb_log[(last_r0 + 2) % 256]), 64'(16'hA500));
        chk("s1_latency", 64'(done_cyc - start_cyc), 64'(NW + CL + 2));

        run_load(0, 1, 40'hA5A5_A5A5_A5, 2, 0, 0);
        run_load(5, 1, 40'hA5A5_A5A5_A5, 0, 0, 0);
        chk("s3_chain", 64'(chain), 64'(40'h12_3456_789A));
        run_load(0, 1, 40'hA5A5_A5A5_A5, 0, 1, 0);

        run_load(0, 1, 40'hA5A5_A5A5_A5, 0, 0, 20);
        run_load(0, 0, '0, 0, 0, 0);
        chk("s5_chain", 64'(chain), 64'(40'h12_3456_789A));

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
            run_load($urandom_range(0, 3), 1, CL'({$urandom, $urandom}), 1, r[0], 0);
        end

        // CHAIN_LEN=1, WORD_W=2 instance
        s_pre_val = 1'b1; s_pre_req = 1'b1; step(); s_pre_req = 1'b0;
        s_rb_ready = 1'b1; s_in_data = 2'b10; s_in_valid = 1'b1; s_start = 1'b1;
        step(); s_start = 1'b0;
        ns = 0; nrb = 0; dat = 0;
        for (int c = 1; c <= 20; c++) begin
            settle();
            if (s_shift_en) begin ns++; chk("small_head", 64'(s_head), 64'(1)); end
            if (s_rb_valid) begin nrb++; chk("small_rb", 64'(s_rb_data), 64'(2'b10)); end
            if (s_done) begin dat = c; break; end
            acc_small: begin
                if (s_in_valid && s_in_ready) begin step(); s_in_valid = 1'b0; end
                else step();
            end
        end
        chk("small_shifts", 64'(ns), 64'(1));
        chk("small_rb_count", 64'(nrb), 64'(1));
        chk("small_done_cycle", 64'(dat), 64'(4));
        step(); settle();
        chk("small_idle", 64'({s_busy, s_done}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
